// File: rtl/axi4lite_ram_bridge.sv
// AXI4-Lite slave bridging one transaction at a time onto a flat
// single-port RAM interface, with window checking and wait states.
module axi4lite_ram_bridge #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SIZE      = 32'h0800_0000,
    parameter int                DELAY     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic [63:0]       ram_raddr,
    input  logic [63:0]       ram_rdata,
    output logic [63:0]       ram_waddr,
    output logic [63:0]       ram_wdata,
    output logic [7:0]        ram_wstrb,
    output logic              ram_wen
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_EXEC, WR_RESP
    } state_t;

    localparam logic [3:0]      DLY   = 4'(DELAY);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, SIZE};

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [63:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ADDR_W-1:0] ar_al, aw_al;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    assign ar_al     = {araddr[ADDR_W-1:3], 3'b000};
    assign aw_al     = {awaddr[ADDR_W-1:3], 3'b000};
    assign ram_raddr = 64'(addr_q);
    assign ram_waddr = 64'(addr_q);
    assign ram_wdata = wdata_q;
    assign ram_wstrb = wstrb_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign bresp     = bresp_q;

    // State and datapath registers; addr_q only ever holds in-window addresses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
        end
    end

    // Next-state and handshake decode; reads win over a simultaneous write
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        ram_wen = 1'b0;
        case (state_q)
            IDLE: begin
                arready = ~reset;
                awready = ~reset & awvalid & wvalid & ~arvalid;
                wready  = awready;
                if (arvalid) begin
                    wcnt_d = DLY;
                    if (in_range(ar_al)) begin
                        addr_d  = ar_al;
                        state_d = RD_ADDR;
                    end else begin
                        rdata_d = '0;
                        rresp_d = 2'b10;
                        state_d = RD_RESP;
                    end
                end else if (awvalid && wvalid) begin
                    wcnt_d  = DLY;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    if (in_range(aw_al)) begin
                        addr_d  = aw_al;
                        state_d = WR_EXEC;
                    end else begin
                        bresp_d = 2'b10;
                        state_d = WR_RESP;
                    end
                end
            end
            RD_ADDR: begin
                if (wcnt_q == 4'd0) state_d = RD_DATA;
                else wcnt_d = wcnt_q - 4'd1;
            end
            RD_DATA: begin
                rdata_d = ram_rdata;
                rresp_d = 2'b00;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) state_d = IDLE;
            end
            WR_EXEC: begin
                if (wcnt_q == 4'd0) begin
                    ram_wen = 1'b1;
                    bresp_d = 2'b00;
                    state_d = WR_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4lite_ram_bridge.sv
// Bench for axi4lite_ram_bridge: DELAY=0 and DELAY=3 instances, a RAM
// behind each, and a transaction-level model compared every cycle.
module tb_axi4lite_ram_bridge;

    localparam longint unsigned BASE = 64'h8000_0000;
    localparam longint unsigned WSZ  = 64'h0800_0000;

    logic        clock;
    logic        rst[2];
    logic        awvalid[2], awready[2];
    logic [31:0] awaddr[2];
    logic        wvalid[2], wready[2];
    logic [63:0] wdata[2];
    logic [7:0]  wstrb[2];
    logic        bvalid[2], bready[2];
    logic [1:0]  bresp[2];
    logic        arvalid[2], arready[2];
    logic [31:0] araddr[2];
    logic        rvalid[2], rready[2];
    logic [63:0] rdata[2];
    logic [1:0]  rresp[2];
    logic [63:0] ram_raddr[2], ram_waddr[2], ram_wdata[2];
    logic [7:0]  ram_wstrb[2];
    logic        ram_wen[2];

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    int wen_cnt[2];
    int wen_cyc[2];
    logic [63:0] wen_addr[2];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) tcyc <= tcyc + 1;

    function automatic void chk(input string nm, input int g,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, g, act, exp);
        end
    endfunction

    function automatic void tmo(input string nm, input int g);
        checks++;
        errors++;
        $display("FAIL timeout %s[%0d]", nm, g);
    endfunction

    function automatic bit inwin(input longint unsigned a);
        return a >= BASE && a < BASE + WSZ;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = g * 3;
        logic [63:0] ram_rd;
        logic [63:0] mem [longint unsigned];

        axi4lite_ram_bridge #(
            .ADDR_W(32), .BASE_ADDR(32'h8000_0000),
            .SIZE(32'h0800_0000), .DELAY(D)
        ) dut (
            .clock(clock), .reset(rst[g]),
            .awvalid(awvalid[g]), .awready(awready[g]), .awaddr(awaddr[g]),
            .wvalid(wvalid[g]), .wready(wready[g]),
            .wdata(wdata[g]), .wstrb(wstrb[g]),
            .bvalid(bvalid[g]), .bready(bready[g]), .bresp(bresp[g]),
            .arvalid(arvalid[g]), .arready(arready[g]), .araddr(araddr[g]),
            .rvalid(rvalid[g]), .rready(rready[g]),
            .rdata(rdata[g]), .rresp(rresp[g]),
            .ram_raddr(ram_raddr[g]), .ram_rdata(ram_rd),
            .ram_waddr(ram_waddr[g]), .ram_wdata(ram_wdata[g]),
            .ram_wstrb(ram_wstrb[g]), .ram_wen(ram_wen[g])
        );

        // RAM: strobed write on wen edge, read data one cycle after address
        always @(posedge clock) begin
            logic [63:0] t;
            if (ram_wen[g]) begin
                t = mem.exists(ram_waddr[g]) ? mem[ram_waddr[g]] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (ram_wstrb[g][b]) t[b*8 +: 8] = ram_wdata[g][b*8 +: 8];
                mem[ram_waddr[g]] = t;
            end
            ram_rd <= mem.exists(ram_raddr[g]) ? mem[ram_raddr[g]] : 64'h0;
        end

        always @(negedge clock) begin
            if (ram_wen[g] && !rst[g]) begin
                wen_cnt[g] = wen_cnt[g] + 1;
                wen_cyc[g] = tcyc;
                wen_addr[g] = ram_waddr[g];
            end
        end

        // Transaction model: one outstanding access, timeline from accept cycle
        bit busy = 0;
        bit is_rd = 0;
        bit inr = 0;
        longint unsigned cyc = 0;
        longint unsigned start = 0;
        logic [63:0] last = BASE;
        logic [63:0] wa = 0;
        logic [63:0] wd = 0;
        logic [7:0]  ws = 0;
        logic [63:0] exp_d = 0;
        logic [1:0]  exp_r = 0;
        logic [63:0] shadow [longint unsigned];

        always @(posedge clock or posedge rst[g]) begin
            longint unsigned a, rl, bl;
            logic [63:0] t;
            if (rst[g]) begin
                busy = 0;
                last = BASE;
            end else begin
                rl = inr ? 64'(3 + D) : 64'd1;
                bl = inr ? 64'(2 + D) : 64'd1;
                if (!busy) begin
                    if (arvalid[g]) begin
                        a = {32'h0, araddr[g]} & ~64'h7;
                        is_rd = 1; busy = 1; start = cyc;
                        inr = inwin(a);
                        if (inr) begin
                            last = a;
                            exp_d = shadow.exists(a) ? shadow[a] : 64'h0;
                            exp_r = 2'b00;
                        end else begin
                            exp_d = 64'h0;
                            exp_r = 2'b10;
                        end
                    end else if (awvalid[g] && wvalid[g]) begin
                        a = {32'h0, awaddr[g]} & ~64'h7;
                        is_rd = 0; busy = 1; start = cyc;
                        inr = inwin(a);
                        wd = wdata[g]; ws = wstrb[g];
                        if (inr) begin
                            last = a; wa = a;
                        end
                        exp_r = inr ? 2'b00 : 2'b10;
                    end
                end else begin
                    if (!is_rd && inr && cyc == start + 1 + D) begin
                        t = shadow.exists(wa) ? shadow[wa] : 64'h0;
                        for (int b = 0; b < 8; b++)
                            if (ws[b]) t[b*8 +: 8] = wd[b*8 +: 8];
                        shadow[wa] = t;
                    end
                    if (is_rd && cyc >= start + rl && rready[g]) busy = 0;
                    if (!is_rd && cyc >= start + bl && bready[g]) busy = 0;
                end
                cyc++;
            end
        end

        always @(negedge clock) begin
            bit e_rv, e_bv, e_wen, e_aw;
            longint unsigned rl, bl;
            if (rst[g]) begin
                chk("arready_rst", g, 64'(arready[g]), 64'h0);
                chk("awready_rst", g, 64'(awready[g]), 64'h0);
                chk("rvalid_rst", g, 64'(rvalid[g]), 64'h0);
                chk("bvalid_rst", g, 64'(bvalid[g]), 64'h0);
                chk("wen_rst", g, 64'(ram_wen[g]), 64'h0);
                chk("raddr_rst", g, ram_raddr[g], BASE);
            end else begin
                rl = inr ? 64'(3 + D) : 64'd1;
                bl = inr ? 64'(2 + D) : 64'd1;
                e_rv = busy && is_rd && cyc >= start + rl;
                e_bv = busy && !is_rd && cyc >= start + bl;
                e_wen = busy && !is_rd && inr && cyc == start + 1 + D;
                e_aw = !busy && awvalid[g] && wvalid[g] && !arvalid[g];
                chk("arready", g, 64'(arready[g]), 64'(!busy));
                chk("awready", g, 64'(awready[g]), 64'(e_aw));
                chk("wready", g, 64'(wready[g]), 64'(e_aw));
                chk("rvalid", g, 64'(rvalid[g]), 64'(e_rv));
                chk("bvalid", g, 64'(bvalid[g]), 64'(e_bv));
                chk("ram_wen", g, 64'(ram_wen[g]), 64'(e_wen));
                chk("ram_raddr", g, ram_raddr[g], last);
                chk("ram_waddr", g, ram_waddr[g], last);
                if (e_rv) begin
                    chk("rdata", g, rdata[g], exp_d);
                    chk("rresp", g, 64'(rresp[g]), 64'(exp_r));
                end
                if (e_bv) chk("bresp", g, 64'(bresp[g]), 64'(exp_r));
                if (e_wen) begin
                    chk("ram_wdata", g, ram_wdata[g], wd);
                    chk("ram_wstrb", g, 64'(ram_wstrb[g]), 64'(ws));
                end
            end
        end
    end

    task automatic rd(input int i, input logic [31:0] a, input int stall,
                      output logic [63:0] d, output logic [1:0] r,
                      output int lat);
        bit ok;
        int n, c0;
        d = '0; r = '0; lat = -1; c0 = 0;
        arvalid[i] = 1; araddr[i] = a; rready[i] = 0;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clock);
            ok = arready[i]; c0 = tcyc; n++;
            if (!ok) begin @(posedge clock); #1; end
        end
        if (!ok) begin tmo("ar_hs", i); arvalid[i] = 0; return; end
        @(posedge clock); #1;
        arvalid[i] = 0;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clock);
            ok = rvalid[i]; n++;
            if (!ok) begin @(posedge clock); #1; end
        end
        if (!ok) begin tmo("rvalid", i); return; end
        lat = tcyc - c0; d = rdata[i]; r = rresp[i];
        repeat (stall) @(negedge clock);
        rready[i] = 1;
        @(posedge clock); #1;
        rready[i] = 0;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [63:0] dt,
                      input logic [7:0] st, input int stall,
                      output logic [1:0] r, output int lat, output int c0);
        bit ok;
        int n;
        r = '0; lat = -1; c0 = 0;
        awvalid[i] = 1; wvalid[i] = 1; awaddr[i] = a;
        wdata[i] = dt; wstrb[i] = st; bready[i] = 0;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clock);
            ok = awready[i] && wready[i]; c0 = tcyc; n++;
            if (!ok) begin @(posedge clock); #1; end
        end
        if (!ok) begin
            tmo("aw_hs", i); awvalid[i] = 0; wvalid[i] = 0; return;
        end
        @(posedge clock); #1;
        awvalid[i] = 0; wvalid[i] = 0;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clock);
            ok = bvalid[i]; n++;
            if (!ok) begin @(posedge clock); #1; end
        end
        if (!ok) begin tmo("bvalid", i); return; end
        lat = tcyc - c0; r = bresp[i];
        repeat (stall) @(negedge clock);
        bready[i] = 1;
        @(posedge clock); #1;
        bready[i] = 0;
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        int lat, c0, w0, t, n;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; awvalid[i] = 0; wvalid[i] = 0; bready[i] = 0;
            arvalid[i] = 0; rready[i] = 0; awaddr[i] = '0; araddr[i] = '0;
            wdata[i] = '0; wstrb[i] = '0; wen_cnt[i] = 0; wen_cyc[i] = 0;
            wen_addr[i] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("lit_arready_in_rst", 0, 64'(arready[0]), 64'h0);
        chk("lit_raddr_in_rst", 0, ram_raddr[0], 64'h8000_0000);
        rst[0] = 0; rst[1] = 0;
        @(negedge clock);
        chk("lit_arready_idle", 0, 64'(arready[0]), 64'h1);
        @(posedge clock); #1;

        w0 = wen_cnt[0];
        wr(0, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 0, r, lat, c0);
        chk("lit_wr_bresp", 0, 64'(r), 64'h0);
        chk("lit_wr_blat", 0, 64'(lat), 64'd2);
        chk("lit_wr_wen_cnt", 0, 64'(wen_cnt[0] - w0), 64'd1);
        chk("lit_wr_wen_lat", 0, 64'(wen_cyc[0] - c0), 64'd1);
        chk("lit_wr_waddr", 0, wen_addr[0], 64'h8000_0010);

        rd(0, 32'h8000_0010, 0, d, r, lat);
        chk("lit_rd_data", 0, d, 64'h1122334455667788);
        chk("lit_rd_resp", 0, 64'(r), 64'h0);
        chk("lit_rd_lat", 0, 64'(lat), 64'd3);

        rd(0, 32'h8000_0013, 0, d, r, lat);
        chk("lit_rd_unal_data", 0, d, 64'h1122334455667788);
        chk("lit_rd_unal_raddr", 0, ram_raddr[0], 64'h8000_0010);

        w0 = wen_cnt[0];
        wr(0, 32'h7FFF_FFF8, 64'hDEAD, 8'hFF, 0, r, lat, c0);
        chk("lit_wr_oor_bresp", 0, 64'(r), 64'h2);
        chk("lit_wr_oor_lat", 0, 64'(lat), 64'd1);
        chk("lit_wr_oor_wen", 0, 64'(wen_cnt[0] - w0), 64'd0);
        chk("lit_wr_oor_waddr", 0, ram_waddr[0], 64'h8000_0010);

        rd(0, 32'h8800_0000, 0, d, r, lat);
        chk("lit_rd_oor_data", 0, d, 64'h0);
        chk("lit_rd_oor_resp", 0, 64'(r), 64'h2);
        chk("lit_rd_oor_lat", 0, 64'(lat), 64'd1);

        rd(0, 32'h87FF_FFF8, 0, d, r, lat);
        chk("lit_rd_top_resp", 0, 64'(r), 64'h0);
        chk("lit_rd_top_lat", 0, 64'(lat), 64'd3);

        wr(0, 32'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, r, lat, c0);
        rd(0, 32'h8000_0010, 0, d, r, lat);
        chk("lit_strobe_merge", 0, d, 64'h11223344AAAAAAAA);

        w0 = wen_cnt[0];
        wr(0, 32'h8000_0020, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, r, lat, c0);
        chk("lit_zstrb_bresp", 0, 64'(r), 64'h0);
        chk("lit_zstrb_wen", 0, 64'(wen_cnt[0] - w0), 64'd1);
        rd(0, 32'h8000_0020, 0, d, r, lat);
        chk("lit_zstrb_data", 0, d, 64'h0);

        awvalid[0] = 1; wvalid[0] = 1; awaddr[0] = 32'h8000_0030;
        wdata[0] = 64'hCAFE; wstrb[0] = 8'hFF;
        rd(0, 32'h8000_0010, 0, d, r, lat);
        chk("lit_race_rd_data", 0, d, 64'h11223344AAAAAAAA);
        t = tcyc;
        wr(0, 32'h8000_0030, 64'hCAFE, 8'hFF, 0, r, lat, c0);
        chk("lit_race_wr_cycle", 0, 64'(c0 - t), 64'd0);
        rd(0, 32'h8000_0030, 0, d, r, lat);
        chk("lit_race_wr_data", 0, d, 64'hCAFE);

        rd(0, 32'h8000_0010, 10, d, r, lat);
        chk("lit_stall_rd_data", 0, d, 64'h11223344AAAAAAAA);
        chk("lit_stall_rd_lat", 0, 64'(lat), 64'd3);
        wr(0, 32'h8000_0040, 64'h55, 8'hFF, 10, r, lat, c0);
        chk("lit_stall_wr_bresp", 0, 64'(r), 64'h0);
        chk("lit_stall_wr_lat", 0, 64'(lat), 64'd2);

        rd(1, 32'h8000_0010, 0, d, r, lat);
        chk("lit_d3_rd_data", 1, d, 64'h0);
        chk("lit_d3_rd_lat", 1, 64'(lat), 64'd6);
        w0 = wen_cnt[1];
        wr(1, 32'h8000_0008, 64'h5, 8'hFF, 0, r, lat, c0);
        chk("lit_d3_wen_cnt", 1, 64'(wen_cnt[1] - w0), 64'd1);
        chk("lit_d3_wen_lat", 1, 64'(wen_cyc[1] - c0), 64'd4);
        chk("lit_d3_blat", 1, 64'(lat), 64'd5);
        rd(1, 32'h8000_0008, 0, d, r, lat);
        chk("lit_d3_rd_back", 1, d, 64'h5);

        w0 = wen_cnt[1];
        awvalid[1] = 1; wvalid[1] = 1; awaddr[1] = 32'h8000_0100;
        wdata[1] = 64'h77; wstrb[1] = 8'hFF;
        ok = 0; n = 0;
        while (!ok && n < 40) begin
            @(negedge clock);
            ok = awready[1]; n++;
            if (!ok) begin @(posedge clock); #1; end
        end
        if (!ok) tmo("rst_aw_hs", 1);
        @(posedge clock); #1;
        awvalid[1] = 0; wvalid[1] = 0;
        @(posedge clock); #1;
        rst[1] = 1;
        #1;
        chk("lit_rst_bvalid", 1, 64'(bvalid[1]), 64'h0);
        chk("lit_rst_wen", 1, 64'(ram_wen[1]), 64'h0);
        chk("lit_rst_arready", 1, 64'(arready[1]), 64'h0);
        repeat (2) @(posedge clock);
        #1;
        rst[1] = 0;
        @(negedge clock);
        chk("lit_rst_arready_after", 1, 64'(arready[1]), 64'h1);
        repeat (6) @(posedge clock);
        #1;
        chk("lit_rst_no_wen", 1, 64'(wen_cnt[1] - w0), 64'd0);
        rd(1, 32'h8000_0100, 0, d, r, lat);
        chk("lit_rst_no_commit", 1, d, 64'h0);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_ram_bridge.md
Name: axi4lite_ram_bridge

Overview:
- AXI4-Lite slave that converts bus read/write transactions into the flat single-port simulation RAM control interface used in the playground: raddr/rdata, waddr/wdata/wstrb/wen, 64-bit data, 8-bit strobe.
- Sits directly upstream of the DPI-backed RAM controller; the core's AXI4-Lite master connects on the other side.
- Handles one transaction at a time. Provides address range checking and a configurable wait-state count so that latency-tolerance of the master can be tested.

Parameters:
- ADDR_W, 32, AXI address width; RAM-side addresses are zero-extended to 64 bits.
- BASE_ADDR, 32'h8000_0000, first valid byte address.
- SIZE, 32'h0800_0000, window size in bytes; valid iff BASE_ADDR <= addr < BASE_ADDR+SIZE.
- DELAY, 0, extra wait cycles (0..15) inserted before every RAM access.

Ports:
- clock in 1 system clock
- reset in 1 asynchronous, active-high reset
- awvalid in 1 / awready out 1 / awaddr in ADDR_W: write address channel
- wvalid in 1 / wready out 1 / wdata in 64 / wstrb in 8: write data channel
- bvalid out 1 / bready in 1 / bresp out 2: write response channel
- arvalid in 1 / arready out 1 / araddr in ADDR_W: read address channel
- rvalid out 1 / rready in 1 / rdata out 64 / rresp out 2: read data channel
- ram_raddr out 64: RAM read address; must always hold an in-range address
- ram_rdata in 64: RAM read data; valid the cycle after the RAM samples ram_raddr
- ram_waddr out 64 / ram_wdata out 64 / ram_wstrb out 8 / ram_wen out 1: RAM write port, committed at the clock edge where ram_wen=1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_EXEC, WR_RESP. A 4-bit wait counter wcnt is shared by both paths.
- Reset (async): state=IDLE, wcnt=0, addr_q=BASE_ADDR, rdata=0, rresp=0, bresp=0; bvalid=rvalid=ram_wen=0 immediately. All ready outputs are 0 while reset is high.
- IDLE: arready=1. awready=wready=(awvalid & wvalid & ~arvalid). Read wins a simultaneous arrival; AW and W are accepted only together.
- Read accept (arvalid & arready):
  - latch araddr with low 3 bits cleared into addr_q, wcnt=DELAY.
  - in range -> RD_ADDR; out of range -> RD_RESP with rdata=0, rresp=2'b10.
- RD_ADDR: ram_raddr=addr_q; decrement wcnt; when wcnt==0 -> RD_DATA.
- RD_DATA (exactly 1 cycle): rdata <= ram_rdata, rresp <= 2'b00 -> RD_RESP.
- RD_RESP: rvalid=1 with rdata/rresp stable until rready; on handshake -> IDLE.
- Write accept:
  - latch awaddr (low 3 bits cleared), wdata, wstrb, wcnt=DELAY.
  - in range -> WR_EXEC; out of range -> WR_RESP with bresp=2'b10, no RAM write.
- WR_EXEC:
  - ram_waddr/ram_wdata/ram_wstrb driven from registers.
  - ram_wen=1 only when wcnt==0; that cycle -> WR_RESP with bresp=2'b00. Otherwise decrement wcnt.
- WR_RESP: bvalid=1 until bready; on handshake -> IDLE.
- ram_wen is decoded from state/wcnt, is never high outside WR_EXEC, and is high for exactly one cycle per in-range write.
- ram_raddr always equals addr_q, which is reset to BASE_ADDR and only ever loaded with an in-range address, so the DPI never sees an out-of-window address. ram_waddr follows the same rule.
- wstrb==0 is legal: the access is performed and the response is OKAY.
- Latency (DELAY=0), counted from the handshake cycle C0:
  - read: rvalid in C3.
  - write: ram_wen in C1, bvalid in C2.
  - each unit of DELAY adds one cycle.
- Reset mid-transaction: the pending access is dropped; a write is not committed unless ram_wen had already been sampled high.

Test Plan:
- Write 0x1122334455667788, strobe 0xFF to 0x80000010, then read 0x80000010 -> ram_wen pulses once with waddr 0x80000010; rdata=0x1122334455667788, rresp=0, rvalid in C3.
- Read 0x80000013 -> ram_raddr=0x80000010 (alignment); write 0x7FFFFFF8 -> bresp=2, ram_wen stays 0; read 0x88000000 -> rdata=0, rresp=2, rvalid in C1.
- arvalid, awvalid and wvalid all asserted in the same cycle -> read accepted first, awready=0; write accepted in the IDLE cycle after the R handshake.
- DELAY=3 build, read -> rvalid in C6; write -> ram_wen in C4 only.
- rready held low 10 cycles -> rvalid and rdata stable, no new arready. Same check for bready.
- Reset asserted during WR_EXEC with DELAY=3 -> ram_wen never pulses, bvalid=0 immediately, arready=1 after release.
